// File: rtl/msrh_l1d_lrq_if.sv
// L1D load request queue port bundle.
// Miss intake, L2 read request, refill search and resolve.
interface msrh_l1d_lrq_if #(
  parameter int PADDR_W  = 56,
  parameter int IDX_W    = 3,
  parameter int L2_TAG_W = 8
);
  logic                i_miss_valid;
  logic [PADDR_W-1:0]  i_miss_paddr;
  logic                o_miss_accept;
  logic                o_miss_merged;
  logic [IDX_W-1:0]    o_miss_index;
  logic                o_full;
  logic                o_l2_req_valid;
  logic [PADDR_W-1:0]  o_l2_req_paddr;
  logic [L2_TAG_W-1:0] o_l2_req_tag;
  logic                i_l2_req_ready;
  logic                i_search_valid;
  logic [IDX_W-1:0]    i_search_index;
  logic [PADDR_W-1:0]  o_search_paddr;
  logic                o_resolve_valid;
  logic [IDX_W-1:0]    o_resolve_index;

  modport slave (
    input  i_miss_valid, i_miss_paddr,
    output o_miss_accept, o_miss_merged,
    output o_miss_index, o_full,
    output o_l2_req_valid, o_l2_req_paddr,
    output o_l2_req_tag,
    input  i_l2_req_ready,
    input  i_search_valid, i_search_index,
    output o_search_paddr,
    output o_resolve_valid, o_resolve_index
  );

  modport master (
    output i_miss_valid, i_miss_paddr,
    input  o_miss_accept, o_miss_merged,
    input  o_miss_index, o_full,
    input  o_l2_req_valid, o_l2_req_paddr,
    input  o_l2_req_tag,
    output i_l2_req_ready,
    output i_search_valid, i_search_index,
    input  o_search_paddr,
    input  o_resolve_valid, o_resolve_index
  );
endinterface

// File: rtl/msrh_l1d_lrq.sv
// L1D load request queue: tracks line misses, issues L2
// line reads and frees entries when the refill searches them.
module msrh_l1d_lrq #(
  parameter int          LRQ_ENTRY_NUM    = 8,
  parameter int          PADDR_W          = 56,
  parameter int          LINE_OFS_W       = 6,
  parameter int          L2_TAG_W         = 8,
  parameter logic [1:0]  UPPER_TAG_RD_L1D = 2'b00
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  msrh_l1d_lrq_if.slave  bus
);
  localparam int N     = LRQ_ENTRY_NUM;
  localparam int IDX_W = $clog2(LRQ_ENTRY_NUM);

  localparam logic [1:0] ST_FREE      = 2'd0;
  localparam logic [1:0] ST_WAIT_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;

  typedef logic [PADDR_W-1:0] paddr_t;

  localparam paddr_t LINE_MASK =
    {{(PADDR_W-LINE_OFS_W){1'b1}}, {LINE_OFS_W{1'b0}}};

  logic [1:0]          state_q [N];
  paddr_t              paddr_q [N];

  logic [N-1:0]        free_vec;
  logic [N-1:0]        wreq_vec;
  logic [N-1:0]        hit_vec;
  logic                hit_any;
  logic                free_any;
  logic                wreq_any;
  logic [IDX_W-1:0]    hit_idx;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    wreq_idx;
  paddr_t              miss_line;
  logic                alloc;
  logic                load;
  logic                srch_ok;

  logic                req_valid_q;
  logic                req_valid_d;
  paddr_t              req_paddr_q;
  logic [L2_TAG_W-1:0] req_tag_q;
  logic [L2_TAG_W-1:0] tag_d;
  logic                resolve_valid_q;
  logic [IDX_W-1:0]    resolve_index_q;

  // Per-entry status and line match against the incoming miss.
  always_comb begin
    miss_line = bus.i_miss_paddr & LINE_MASK;
    free_vec  = '0;
    wreq_vec  = '0;
    hit_vec   = '0;
    for (int i = 0; i < N; i++) begin
      free_vec[i] = (state_q[i] == ST_FREE);
      wreq_vec[i] = (state_q[i] == ST_WAIT_REQ);
      hit_vec[i]  = (state_q[i] != ST_FREE) &&
                    (paddr_q[i] == miss_line) &&
                    !(bus.i_search_valid &&
                      (bus.i_search_index == IDX_W'(i)));
    end
  end

  // Lowest-index pickers for match, allocation and issue.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    wreq_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit_vec[i])  hit_idx  = IDX_W'(i);
      if (free_vec[i]) free_idx = IDX_W'(i);
      if (wreq_vec[i]) wreq_idx = IDX_W'(i);
    end
  end

  assign hit_any  = |hit_vec;
  assign free_any = |free_vec;
  assign wreq_any = |wreq_vec;

  assign alloc   = bus.i_miss_valid && !hit_any && free_any;
  assign load    = (!req_valid_q || bus.i_l2_req_ready) && wreq_any;
  assign srch_ok = bus.i_search_valid &&
                   (state_q[bus.i_search_index] == ST_WAIT_RESP);

  assign bus.o_miss_accept = bus.i_miss_valid && (hit_any || free_any);
  assign bus.o_miss_merged = bus.i_miss_valid && hit_any;
  assign bus.o_miss_index  = !bus.i_miss_valid ? '0 :
                             hit_any  ? hit_idx  :
                             free_any ? free_idx : '0;
  assign bus.o_full        = !free_any;
  assign bus.o_search_paddr = paddr_q[bus.i_search_index];

  // Request tag: requester field on top, entry index at the bottom.
  always_comb begin
    tag_d = '0;
    tag_d[IDX_W-1:0] = wreq_idx;
    tag_d[L2_TAG_W-1 -: 2] = UPPER_TAG_RD_L1D;
  end

  assign req_valid_d = load ? 1'b1 :
                       bus.i_l2_req_ready ? 1'b0 : req_valid_q;

  // Entry lifecycle: allocate, hand to request register, free on search.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_FREE;
        paddr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alloc && (free_idx == IDX_W'(i))) begin
          state_q[i] <= ST_WAIT_REQ;
          paddr_q[i] <= miss_line;
        end else if (load && (wreq_idx == IDX_W'(i))) begin
          state_q[i] <= ST_WAIT_RESP;
        end else if (srch_ok &&
                     (bus.i_search_index == IDX_W'(i))) begin
          state_q[i] <= ST_FREE;
        end
      end
    end
  end

  // Single-stage L2 request register; payload holds while stalled.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      req_valid_q <= 1'b0;
      req_paddr_q <= '0;
      req_tag_q   <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      if (load) begin
        req_paddr_q <= paddr_q[wreq_idx];
        req_tag_q   <= tag_d;
      end
    end
  end

  // One-cycle resolve pulse for the entry freed by a search.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      resolve_valid_q <= 1'b0;
      resolve_index_q <= '0;
    end else begin
      resolve_valid_q <= srch_ok;
      if (srch_ok) resolve_index_q <= bus.i_search_index;
    end
  end

  assign bus.o_l2_req_valid  = req_valid_q;
  assign bus.o_l2_req_paddr  = req_paddr_q;
  assign bus.o_l2_req_tag    = req_tag_q;
  assign bus.o_resolve_valid = resolve_valid_q;
  assign bus.o_resolve_index = resolve_index_q;

`ifdef SIMULATION
  // Searching an entry with no outstanding L2 read is a protocol error.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && bus.i_search_valid && !srch_ok)
      $fatal(1, "lrq: search of idle entry %0d", bus.i_search_index);
  end
`endif
endmodule

// File: tb/tb_msrh_l1d_lrq.sv
// Bench for the L1D load request queue.
// Directed scenarios plus a randomized run against a reference model.
module tb_msrh_l1d_lrq;
  localparam int PW = 56;
  localparam int IW = 3;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  msrh_l1d_lrq_if #(.PADDR_W(PW), .IDX_W(IW), .L2_TAG_W(TW)) bus();

  msrh_l1d_lrq dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // reference model: entry status 0 idle, 1 waiting issue, 2 issued
  int          m_st [8];
  logic [PW-1:0] m_line [8];
  bit          m_rv;
  logic [PW-1:0] m_rpaddr;
  int          m_rtag;
  bit          m_resv;
  int          m_resi;
  bit          e_accept, e_merged, e_full, e_alloc;
  int          e_index;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.i_miss_valid   = 1'b0;
    bus.i_miss_paddr   = '0;
    bus.i_l2_req_ready = 1'b0;
    bus.i_search_valid = 1'b0;
    bus.i_search_index = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_st[i] = 0;
      m_line[i] = '0;
    end
    m_rv = 0; m_rpaddr = '0; m_rtag = 0;
    m_resv = 0; m_resi = 0;
  endfunction

  function automatic void model_eval();
    logic [PW-1:0] a;
    bit hit, fr;
    int hi, fi;
    a = bus.i_miss_paddr & ~(56'h3f);
    hit = 0; fr = 0; hi = 0; fi = 0;
    for (int i = 0; i < 8; i++) begin
      if (!hit && m_st[i] != 0 && m_line[i] == a &&
          !(bus.i_search_valid && int'(bus.i_search_index) == i)) begin
        hit = 1; hi = i;
      end
      if (!fr && m_st[i] == 0) begin
        fr = 1; fi = i;
      end
    end
    e_full   = !fr;
    e_accept = bus.i_miss_valid && (hit || fr);
    e_merged = bus.i_miss_valid && hit;
    e_alloc  = bus.i_miss_valid && !hit && fr;
    e_index  = !bus.i_miss_valid ? 0 : hit ? hi : fr ? fi : 0;
  endfunction

  function automatic void model_commit();
    int j, si, ai;
    bit ld, sok;
    logic [PW-1:0] a;
    a  = bus.i_miss_paddr & ~(56'h3f);
    ai = e_index;
    j = -1;
    for (int i = 7; i >= 0; i--) if (m_st[i] == 1) j = i;
    ld = (!m_rv || bus.i_l2_req_ready) && (j >= 0);
    si = int'(bus.i_search_index);
    sok = bus.i_search_valid && m_st[si] == 2;
    if (ld) begin
      m_rv = 1; m_rpaddr = m_line[j]; m_rtag = j; m_st[j] = 2;
    end else if (bus.i_l2_req_ready) begin
      m_rv = 0;
    end
    if (sok) begin
      m_st[si] = 0; m_resv = 1; m_resi = si;
    end else begin
      m_resv = 0;
    end
    if (e_alloc) begin
      m_st[ai] = 1; m_line[ai] = a;
    end
  endfunction

  task automatic test_reset();
    do_reset();
    #2;
    n_cmp++; if (bus.o_l2_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid got %0b exp 0", bus.o_l2_req_valid); end
    n_cmp++; if (bus.o_full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %0b exp 0", bus.o_full); end
    n_cmp++; if (bus.o_resolve_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resolve got %0b exp 0", bus.o_resolve_valid); end
    n_cmp++; if (bus.o_l2_req_paddr !== '0) begin n_bad++; $display("FAIL rst_req_paddr got %h exp 0", bus.o_l2_req_paddr); end
    n_cmp++; if (bus.o_l2_req_tag !== 8'h00) begin n_bad++; $display("FAIL rst_req_tag got %h exp 00", bus.o_l2_req_tag); end
    n_cmp++; if (bus.o_resolve_index !== 3'd0) begin n_bad++; $display("FAIL rst_res_idx got %0d exp 0", bus.o_resolve_index); end
    tick();
  endtask

  task automatic test_single_miss();
    do_reset();
    bus.i_miss_valid = 1'b1;
    bus.i_miss_paddr = 56'h8000_1234;
    #2;
    n_cmp++; if (bus.o_miss_accept !== 1'b1) begin n_bad++; $display("FAIL one_accept got %0b exp 1", bus.o_miss_accept); end
    n_cmp++; if (bus.o_miss_merged !== 1'b0) begin n_bad++; $display("FAIL one_merged got %0b exp 0", bus.o_miss_merged); end
    n_cmp++; if (bus.o_miss_index !== 3'd0) begin n_bad++; $display("FAIL one_index got %0d exp 0", bus.o_miss_index); end
    tick();
    bus.i_miss_valid = 1'b0;
    #2;
    n_cmp++; if (bus.o_l2_req_valid !== 1'b0) begin n_bad++; $display("FAIL one_early_req got %0b exp 0", bus.o_l2_req_valid); end
    tick();
    for (int k = 0; k < 3; k++) begin
      #2;
      n_cmp++; if (bus.o_l2_req_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid c%0d got %0b exp 1", k, bus.o_l2_req_valid); end
      n_cmp++; if (bus.o_l2_req_paddr !== 56'h8000_1200) begin n_bad++; $display("FAIL stall_paddr c%0d got %h exp 80001200", k, bus.o_l2_req_paddr); end
      n_cmp++; if (bus.o_l2_req_tag !== 8'h00) begin n_bad++; $display("FAIL stall_tag c%0d got %h exp 00", k, bus.o_l2_req_tag); end
      tick();
    end
    bus.i_l2_req_ready = 1'b1;
    tick();
    bus.i_l2_req_ready = 1'b0;
    #2;
    n_cmp++; if (bus.o_l2_req_valid !== 1'b0) begin n_bad++; $display("FAIL one_drop got %0b exp 0", bus.o_l2_req_valid); end
    tick();
  endtask

  task automatic test_merge();
    int nreq;
    do_reset();
    bus.i_l2_req_ready = 1'b1;
    bus.i_miss_valid = 1'b1;
    bus.i_miss_paddr = 56'h1000;
    tick();
    bus.i_miss_paddr = 56'h1038;
    #2;
    n_cmp++; if (bus.o_miss_accept !== 1'b1) begin n_bad++; $display("FAIL mrg_accept got %0b exp 1", bus.o_miss_accept); end
    n_cmp++; if (bus.o_miss_merged !== 1'b1) begin n_bad++; $display("FAIL mrg_merged got %0b exp 1", bus.o_miss_merged); end
    n_cmp++; if (bus.o_miss_index !== 3'd0) begin n_bad++; $display("FAIL mrg_index got %0d exp 0", bus.o_miss_index); end
    tick();
    bus.i_miss_valid = 1'b0;
    nreq = 0;
    for (int k = 0; k < 6; k++) begin
      #2;
      if (bus.o_l2_req_valid === 1'b1) nreq++;
      tick();
    end
    n_cmp++; if (nreq !== 1) begin n_bad++; $display("FAIL mrg_nreq got %0d exp 1", nreq); end
  endtask

  task automatic test_full();
    do_reset();
    bus.i_l2_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.i_miss_valid = 1'b1;
      bus.i_miss_paddr = 56'h10000 + 56'(i * 64);
      #2;
      n_cmp++; if (bus.o_miss_index !== 3'(i)) begin n_bad++; $display("FAIL fill_idx e%0d got %0d exp %0d", i, bus.o_miss_index, i); end
      tick();
    end
    bus.i_miss_valid = 1'b0;
    repeat (10) tick();
    #2;
    n_cmp++; if (bus.o_full !== 1'b1) begin n_bad++; $display("FAIL full_flag got %0b exp 1", bus.o_full); end
    bus.i_miss_valid = 1'b1;
    bus.i_miss_paddr = 56'h20000;
    #1;
    n_cmp++; if (bus.o_miss_accept !== 1'b0) begin n_bad++; $display("FAIL full_accept got %0b exp 0", bus.o_miss_accept); end
    n_cmp++; if (bus.o_miss_index !== 3'd0) begin n_bad++; $display("FAIL full_index got %0d exp 0", bus.o_miss_index); end
    tick();
    bus.i_miss_valid = 1'b0;
    bus.i_search_valid = 1'b1;
    bus.i_search_index = 3'd3;
    #2;
    n_cmp++; if (bus.o_search_paddr !== 56'h100c0) begin n_bad++; $display("FAIL srch_paddr got %h exp 100c0", bus.o_search_paddr); end
    tick();
    bus.i_search_valid = 1'b0;
    #2;
    n_cmp++; if (bus.o_resolve_valid !== 1'b1) begin n_bad++; $display("FAIL res_valid got %0b exp 1", bus.o_resolve_valid); end
    n_cmp++; if (bus.o_resolve_index !== 3'd3) begin n_bad++; $display("FAIL res_index got %0d exp 3", bus.o_resolve_index); end
    n_cmp++; if (bus.o_full !== 1'b0) begin n_bad++; $display("FAIL res_full got %0b exp 0", bus.o_full); end
    tick();
    bus.i_miss_valid = 1'b1;
    bus.i_miss_paddr = 56'h30000;
    #2;
    n_cmp++; if (bus.o_resolve_valid !== 1'b0) begin n_bad++; $display("FAIL res_pulse got %0b exp 0", bus.o_resolve_valid); end
    n_cmp++; if (bus.o_miss_index !== 3'd3) begin n_bad++; $display("FAIL reuse_idx got %0d exp 3", bus.o_miss_index); end
    tick();
    bus.i_miss_valid = 1'b0;
  endtask

  task automatic test_search_alloc();
    do_reset();
    bus.i_l2_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_miss_valid = 1'b1;
      bus.i_miss_paddr = 56'h5000 + 56'(i * 64);
      tick();
    end
    bus.i_miss_valid = 1'b0;
    repeat (5) tick();
    bus.i_search_valid = 1'b1;
    bus.i_search_index = 3'd2;
    bus.i_miss_valid = 1'b1;
    bus.i_miss_paddr = 56'h5090;
    #2;
    n_cmp++; if (bus.o_miss_merged !== 1'b0) begin n_bad++; $display("FAIL sa_merged got %0b exp 0", bus.o_miss_merged); end
    n_cmp++; if (bus.o_miss_index !== 3'd3) begin n_bad++; $display("FAIL sa_index got %0d exp 3", bus.o_miss_index); end
    tick();
    bus.i_search_valid = 1'b0;
    bus.i_miss_paddr = 56'h7000;
    #2;
    n_cmp++; if (bus.o_resolve_index !== 3'd2) begin n_bad++; $display("FAIL sa_res got %0d exp 2", bus.o_resolve_index); end
    n_cmp++; if (bus.o_miss_index !== 3'd2) begin n_bad++; $display("FAIL sa_free2 got %0d exp 2", bus.o_miss_index); end
    tick();
    bus.i_miss_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.i_l2_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.i_miss_valid = (k < 4);
      bus.i_miss_paddr = 56'h9000 + 56'(k * 64);
      #2;
      if (k >= 2 && k < 6) begin
        n_cmp++; if (bus.o_l2_req_valid !== 1'b1 || bus.o_l2_req_tag !== 8'(k - 2)) begin n_bad++; $display("FAIL b2b c%0d got v%0b t%h exp v1 t%h", k, bus.o_l2_req_valid, bus.o_l2_req_tag, 8'(k - 2)); end
      end else begin
        n_cmp++; if (bus.o_l2_req_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle c%0d got %0b exp 0", k, bus.o_l2_req_valid); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.i_miss_valid = 1'b1;
      bus.i_miss_paddr = 56'hA000 + 56'(i * 64);
      tick();
    end
    bus.i_miss_valid = 1'b0;
    tick();
    #1;
    n_cmp++; if (bus.o_l2_req_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre got %0b exp 1", bus.o_l2_req_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_l2_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_req got %0b exp 0", bus.o_l2_req_valid); end
    n_cmp++; if (bus.o_full !== 1'b0) begin n_bad++; $display("FAIL mid_full got %0b exp 0", bus.o_full); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.i_l2_req_ready = 1'b1;
    bus.i_miss_valid = 1'b1;
    bus.i_miss_paddr = 56'hB040;
    #2;
    n_cmp++; if (bus.o_miss_index !== 3'd0 || bus.o_miss_merged !== 1'b0) begin n_bad++; $display("FAIL mid_idx got %0d m%0b exp 0 m0", bus.o_miss_index, bus.o_miss_merged); end
    n_cmp++; if (bus.o_l2_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale got %0b exp 0", bus.o_l2_req_valid); end
    tick();
    bus.i_miss_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int cand [$];
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      bus.i_miss_valid = ($urandom_range(0, 99) < 60);
      bus.i_miss_paddr = 56'h40_0000 + 56'($urandom_range(0, 11) * 64)
                         + 56'($urandom_range(0, 63));
      bus.i_l2_req_ready = ($urandom_range(0, 99) < 70);
      cand.delete();
      for (int i = 0; i < 8; i++) if (m_st[i] == 2) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 99) < 40) begin
        bus.i_search_valid = 1'b1;
        bus.i_search_index = 3'(cand[$urandom_range(0, cand.size() - 1)]);
      end else begin
        bus.i_search_valid = 1'b0;
        bus.i_search_index = 3'($urandom_range(0, 7));
      end
      #2;
      model_eval();
      n_cmp++; if (bus.o_miss_accept !== e_accept || bus.o_miss_merged !== e_merged || bus.o_miss_index !== 3'(e_index)) begin n_bad++; $display("FAIL rnd_miss c%0d got a%0b m%0b i%0d exp a%0b m%0b i%0d", c, bus.o_miss_accept, bus.o_miss_merged, bus.o_miss_index, e_accept, e_merged, e_index); end
      n_cmp++; if (bus.o_full !== e_full) begin n_bad++; $display("FAIL rnd_full c%0d got %0b exp %0b", c, bus.o_full, e_full); end
      n_cmp++; if (bus.o_l2_req_valid !== m_rv) begin n_bad++; $display("FAIL rnd_rv c%0d got %0b exp %0b", c, bus.o_l2_req_valid, m_rv); end
      if (m_rv) begin
        n_cmp++; if (bus.o_l2_req_paddr !== m_rpaddr || bus.o_l2_req_tag !== 8'(m_rtag)) begin n_bad++; $display("FAIL rnd_req c%0d got %h/%h exp %h/%h", c, bus.o_l2_req_paddr, bus.o_l2_req_tag, m_rpaddr, 8'(m_rtag)); end
      end
      n_cmp++; if (bus.o_resolve_valid !== m_resv) begin n_bad++; $display("FAIL rnd_resv c%0d got %0b exp %0b", c, bus.o_resolve_valid, m_resv); end
      if (m_resv) begin
        n_cmp++; if (bus.o_resolve_index !== 3'(m_resi)) begin n_bad++; $display("FAIL rnd_resi c%0d got %0d exp %0d", c, bus.o_resolve_index, m_resi); end
      end
      if (bus.i_search_valid) begin
        n_cmp++; if (bus.o_search_paddr !== m_line[bus.i_search_index]) begin n_bad++; $display("FAIL rnd_spaddr c%0d got %h exp %h", c, bus.o_search_paddr, m_line[bus.i_search_index]); end
      end
      model_commit();
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_miss();
    test_merge();
    test_full();
    test_search_alloc();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/msrh_l1d_lrq.md
Name: msrh_l1d_lrq

Overview:
- L1D Load Request Queue: the initiator side of the L1D refill protocol.
- Allocates an entry per L1D line miss and merges misses to a line already outstanding.
- Issues line-read requests to L2, tagged {UPPER_TAG_RD_L1D, entry index}.
- Serves the refill path's index-based search, which returns the entry's paddr; the searched entry is freed and a resolve broadcast is sent so stalled loads replay.

Parameters:
- LRQ_ENTRY_NUM, 8, number of entries (power of 2); IDX_W = $clog2(LRQ_ENTRY_NUM).
- PADDR_W, 56, physical address width.
- LINE_OFS_W, 6, log2 of line bytes (64B line).
- L2_TAG_W, 8, L2 command tag width; bits [L2_TAG_W-1:L2_TAG_W-2] are the requester field.
- UPPER_TAG_RD_L1D, 2'b00, requester field value for L1D reads.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_miss_valid  in  1  load pipe reports an L1D miss.
- i_miss_paddr  in  PADDR_W  miss address (any byte in the line).
- o_miss_accept  out  1  miss allocated or merged this cycle (combinational).
- o_miss_merged  out  1  miss matched an outstanding entry; no new allocation (combinational).
- o_miss_index  out  IDX_W  entry allocated or matched (combinational).
- o_full  out  1  no FREE entry (registered state).
- o_l2_req_valid  out  1  L2 read request valid.
- o_l2_req_paddr  out  PADDR_W  line-aligned address, low LINE_OFS_W bits zero.
- o_l2_req_tag  out  L2_TAG_W  {UPPER_TAG_RD_L1D, zero pad, entry index}.
- i_l2_req_ready  in  1  L2 accepts the request.
- i_search_valid  in  1  refill stage searches an entry.
- i_search_index  in  IDX_W  entry to search.
- o_search_paddr  out  PADDR_W  line-aligned paddr of the searched entry (combinational).
- o_resolve_valid  out  1  entry freed; loads waiting on it may replay.
- o_resolve_index  out  IDX_W  freed entry.

Behaviour:
- Reset: all entries FREE.
  - o_l2_req_valid = 0, o_resolve_valid = 0, o_full = 0.
  - Registered payloads (o_l2_req_paddr, o_l2_req_tag, o_resolve_index) reset to 0.
- Entry state machine: FREE -> WAIT_REQ (allocate) -> WAIT_RESP (loaded into request register) -> FREE (searched).
- Line match: entry state != FREE, entry paddr[PADDR_W-1:LINE_OFS_W] == miss paddr[PADDR_W-1:LINE_OFS_W], and the entry is not the one being searched this cycle.
  - On a match: o_miss_accept = 1, o_miss_merged = 1, o_miss_index = the matching entry; no allocation.
- No match and a FREE entry exists: allocate the lowest FREE index.
  - Store the line-aligned paddr, state -> WAIT_REQ at the next edge.
  - o_miss_accept = 1, o_miss_merged = 0.
- No match and full: o_miss_accept = 0, o_miss_merged = 0, o_miss_index = 0.
- An entry freed by a search in cycle N is not allocatable until N+1; allocation uses pre-edge state.
- Request register, single stage, valid/ready:
  - Loads when it is empty, or is being accepted this cycle, and at least one entry is in WAIT_REQ.
  - Selects the lowest WAIT_REQ index; that entry goes WAIT_REQ -> WAIT_RESP at the same edge.
  - While o_l2_req_valid = 1 and i_l2_req_ready = 0, o_l2_req_paddr and o_l2_req_tag are held stable.
  - Back-to-back issue: one request per cycle when ready is held high.
  - Latency: miss accepted in cycle N -> o_l2_req_valid earliest in cycle N+2.
- Search:
  - o_search_paddr = paddr[i_search_index] combinationally, every cycle.
  - When i_search_valid = 1 and the entry is WAIT_RESP: the entry goes FREE at the next edge, and o_resolve_valid = 1, o_resolve_index = i_search_index for exactly one cycle (N+1).
  - Search of a FREE or WAIT_REQ entry is a protocol error: state unchanged, no resolve. The SIMULATION build issues $fatal.
- At most one search per cycle.
- Allocation and free of different entries in the same cycle are both honoured.
- Reset asserted mid-operation discards all entries and any pending request immediately (async). No L2 request is presented after reset.

Test Plan:
- Reset, then miss paddr 0x8000_1234 -> accept=1, merged=0, index=0. Two cycles later: req_valid=1, req_paddr=0x8000_1200, req_tag=0x00. Hold ready=0 for 3 cycles -> payload stable; then ready=1 -> req_valid drops the next cycle.
- Misses 0x1000 then 0x1038 (same line) -> second: accept=1, merged=1, index=0; only one L2 request issued.
- Fill 8 distinct lines -> o_full=1. Ninth distinct miss -> accept=0. Search index 3 (WAIT_RESP) -> resolve_valid=1, resolve_index=3 the next cycle, o_full=0. Next distinct miss -> index=3.
- Search index 2 and same-cycle miss to entry 2's line -> new entry allocated (merged=0); entry 2 is FREE the next cycle.
- 4 misses in consecutive cycles with ready=1 -> 4 requests on consecutive cycles, tags 0x00..0x03 in order.
- Reset asserted while req_valid=1 and 5 entries busy -> req_valid=0 and o_full=0 immediately. After release, miss -> index=0.
